// File: rtl/aes128_type_pkg.sv
// aes128_type_pkg: shared AES-128 state types and constants
package aes128_type_pkg;
  localparam int AES128_STATE_BYTES = 16;
  typedef logic [AES128_STATE_BYTES-1:0][7:0] aes128_state_t;
  typedef enum logic {FILL, DRAIN} sr_state_e;
endpackage

// File: rtl/aes128_shift_rows_addr_map.sv
// aes128_shift_rows_addr_map: maps a state index (4*col+row) to its (Inv)ShiftRows destination
// Ports: addr (source index), inv (1 = InvShiftRows), idx (destination index)
module aes128_shift_rows_addr_map (
  input  logic [3:0] addr,
  input  logic       inv,
  output logic [3:0] idx
);
  logic [1:0] r, c;
  assign r = addr[1:0];
  assign c = addr[3:2];
  // 2-bit column arithmetic wraps mod 4 for free
  assign idx = {inv ? c + r : c - r, r};
endmodule

// File: rtl/aes128_shift_rows.sv
// aes128_shift_rows: byte-serial ShiftRows stage with a 16-byte state buffer
// Ports: clk_i, rst_i (sync, active-high); data_i/addr_i/valid_i input byte stream;
//   ready_o (FILL), data_o/addr_o/valid_o output byte stream, done_o (pulse after last byte),
//   state_o (parallel buffer view), err_o (sticky overrun).
// Optional: AES128_SHIFT_ROWS_INV_EN adds inv_i selecting InvShiftRows per write.
module aes128_shift_rows
  import aes128_type_pkg::*;
#(
  parameter int N_BYTES = AES128_STATE_BYTES
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              data_i,
  input  logic [3:0]              addr_i,
  input  logic                    valid_i,
`ifdef AES128_SHIFT_ROWS_INV_EN
  input  logic                    inv_i,
`endif
  output logic                    ready_o,
  output logic [7:0]              data_o,
  output logic [3:0]              addr_o,
  output logic                    valid_o,
  output logic                    done_o,
  output logic [N_BYTES-1:0][7:0] state_o,
  output logic                    err_o
);
  sr_state_e              state_q, state_d;
  logic [N_BYTES-1:0][7:0] buf_q;
  logic [15:0]            mask_q, mask_set;
  logic [3:0]             cnt_q, wr_idx;
  logic                   done_q, err_q, inv;
`ifdef AES128_SHIFT_ROWS_INV_EN
  assign inv = inv_i;
`else
  assign inv = 1'b0;
`endif
  aes128_shift_rows_addr_map u_map (.addr(addr_i), .inv(inv), .idx(wr_idx));
  assign mask_set = mask_q | (16'd1 << addr_i);
  always_comb begin
    state_d = state_q;
    if (state_q == FILL) state_d = (valid_i && mask_set == 16'hFFFF) ? DRAIN : FILL;
    else state_d = (cnt_q == 4'hF) ? FILL : DRAIN;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      buf_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DRAIN && cnt_q == 4'hF;
      if (state_q == FILL && valid_i) begin
        buf_q[wr_idx] <= data_i;
        mask_q        <= mask_set;
      end
      if (state_q == DRAIN) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'hF) mask_q <= '0;
        if (valid_i) err_q <= 1'b1;
      end
    end
  end
  assign ready_o = state_q == FILL;
  assign valid_o = state_q == DRAIN;
  assign data_o  = valid_o ? buf_q[cnt_q] : 8'h00;
  assign addr_o  = valid_o ? cnt_q : 4'h0;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign state_o = buf_q;
endmodule

// File: tb/tb_aes128_shift_rows.sv
// tb_aes128_shift_rows: directed table-driven bench for aes128_shift_rows
module tb_aes128_shift_rows;
  logic             clk_i = 0, rst_i = 1, valid_i = 0, inv_i = 0;
  logic [7:0]       data_i = 0, data_o;
  logic [3:0]       addr_i = 0, addr_o;
  logic             ready_o, valid_o, done_o, err_o;
  logic [15:0][7:0] state_o;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t fwd[16];
  logic [7:0] fwd_exp[16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                              8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  logic [7:0] inv_exp[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                              8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] e[16];

  always #5 clk_i = ~clk_i;

  aes128_shift_rows dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .addr_i(addr_i), .valid_i(valid_i),
`ifdef AES128_SHIFT_ROWS_INV_EN
    .inv_i(inv_i),
`endif
    .ready_o(ready_o), .data_o(data_o), .addr_o(addr_o), .valid_o(valid_o),
    .done_o(done_o), .state_o(state_o), .err_o(err_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    valid_i = 1; addr_i = a; data_i = d;
    step();
    valid_i = 0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) wr(4'(i), base + 8'(i));
  endtask

  task automatic drain(input logic [7:0] ex[16], input int ov);
    int w = 0;
    while (!valid_o && w < 40) begin step(); w++; end
    chk("drain_latency", w, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == ov) begin valid_i = 1; addr_i = 3; data_i = 8'hFF; end
      chk("valid_o", int'(valid_o), 1);
      chk("addr_o", int'(addr_o), k);
      chk("data_o", int'(data_o), int'(ex[k]));
      chk("ready_o_drain", int'(ready_o), 0);
      step();
      valid_i = 0;
    end
    chk("done_o", int'(done_o), 1);
    chk("ready_o_done", int'(ready_o), 1);
    chk("valid_o_done", int'(valid_o), 0);
    for (int k = 0; k < 16; k++) chk("state_o", int'(state_o[k]), int'(ex[k]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) fwd[i] = '{addr: 4'(i), data: 8'(i), exp: fwd_exp[i]};
    step(); step();
    rst_i = 0;
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_state", int'(state_o == '0), 1);
    // forward mapping, table driven
    for (int i = 0; i < 16; i++) begin
      chk("fill_valid_o", int'(valid_o), 0);
      wr(fwd[i].addr, fwd[i].data);
    end
    for (int i = 0; i < 16; i++) e[i] = fwd[i].exp;
    drain(e, -1);
    step();
    chk("done_pulse", int'(done_o), 0);
`ifdef AES128_SHIFT_ROWS_INV_EN
    inv_i = 1;
    fill(8'h00);
    inv_i = 0;
    drain(inv_exp, -1);
`endif
    // out-of-order with duplicate at addr 7, overrun at drain cycle 5
    for (int a = 15; a >= 8; a--) wr(4'(a), 8'(a));
    wr(4'd7, 8'hAA);
    wr(4'd7, 8'h07);
    for (int a = 6; a >= 0; a--) begin
      chk("ooo_no_drain", int'(valid_o), 0);
      wr(4'(a), 8'(a));
    end
    drain(fwd_exp, 5);
    chk("err_set", int'(err_o), 1);
    // back-to-back: first byte of next state lands in the done_o cycle
    fill(8'h10);
    for (int i = 0; i < 16; i++) e[i] = fwd_exp[i] + 8'h10;
    drain(e, -1);
    chk("err_sticky", int'(err_o), 1);
    // reset mid-drain at count 8
    fill(8'h20);
    for (int k = 0; k < 8; k++) step();
    chk("pre_rst_addr", int'(addr_o), 8);
    rst_i = 1;
    step();
    rst_i = 0;
    chk("mrst_valid", int'(valid_o), 0);
    chk("mrst_ready", int'(ready_o), 1);
    chk("mrst_state", int'(state_o == '0), 1);
    chk("mrst_err", int'(err_o), 0);
    chk("mrst_data", int'(data_o), 0);
    chk("mrst_addr", int'(addr_o), 0);
    fill(8'h30);
    for (int i = 0; i < 16; i++) e[i] = fwd_exp[i] + 8'h30;
    drain(e, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
